// File: rtl/gray_step_tracker_pkg.sv
// Shared types and constants for the Gray-coded position step tracker.
// Holds the tracker state encoding, field widths and the step-delta helper.
package gray_step_tracker_pkg;

    localparam int GRAY_W    = 4;
    localparam int ERR_CNT_W = 4;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        FAULT    = 2'd2
    } state_e;

    // Modular distance from the previous binary position to the new one.
    function automatic logic [GRAY_W-1:0] step_delta(
        input logic [GRAY_W-1:0] cur_b,
        input logic [GRAY_W-1:0] prev_b
    );
        return cur_b - prev_b;
    endfunction

endpackage

// File: rtl/gray_step_tracker_gray2bin4bit.sv
// Combinational 4-bit Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin4bit
    import gray_step_tracker_pkg::*;
(
    input  logic [GRAY_W-1:0] gin,
    output logic [GRAY_W-1:0] bout
);

    assign bout[GRAY_W-1] = gin[GRAY_W-1];

    generate
        for (genvar gi = GRAY_W - 2; gi >= 0; gi--) begin : g_bit
            assign bout[gi] = bout[gi+1] ^ gin[gi];
        end
    endgenerate

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks a 4-bit Gray-coded position stream, accumulating single steps into pos
// and flagging illegal multi-bit jumps; all outputs come straight from flops.
module gray_step_tracker
    import gray_step_tracker_pkg::*;
#(
    parameter int POS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gin_valid,
    input  logic [GRAY_W-1:0]    gin,
    input  logic                 pos_clr,
    output logic [POS_W-1:0]     pos,
    output logic                 step,
    output logic                 dir,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 locked
);

    state_e               state_q,   state_d;
    logic [GRAY_W-1:0]    prev_b_q,  prev_b_d;
    logic [POS_W-1:0]     pos_q,     pos_d;
    logic                 step_q,    step_d;
    logic                 dir_q,     dir_d;
    logic                 err_q,     err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 locked_q,  locked_d;

    logic [GRAY_W-1:0]    bin;
    logic [GRAY_W-1:0]    delta;

    gray2bin4bit u_gray2bin (
        .gin  (gin),
        .bout (bin)
    );

    assign delta = step_delta(bin, prev_b_q);

    always_comb begin
        state_d   = state_q;
        prev_b_d  = prev_b_q;
        pos_d     = pos_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (gin_valid) begin
            prev_b_d = bin;
            case (state_q)
                TRACK: begin
                    if (delta == GRAY_W'(1)) begin
                        pos_d  = pos_q + POS_W'(1);
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                    end else if (delta == {GRAY_W{1'b1}}) begin
                        pos_d  = pos_q - POS_W'(1);
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                    end else if (delta != '0) begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                        if (err_cnt_q != ERR_CNT_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // First sample after reset or a fault only establishes the reference.
                    state_d = TRACK;
                end
            endcase
        end

        if (pos_clr) begin
            pos_d = '0;
        end

        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            prev_b_q  <= '0;
            pos_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_b_q  <= prev_b_d;
            pos_q     <= pos_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= locked_d;
        end
    end

    assign pos     = pos_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed bench for gray_step_tracker: each task drives one scenario and checks
// the packed output word {locked, err_cnt, err, dir, step, pos} against hand values.
module tb_gray_step_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gin_valid = 1'b0;
    logic [3:0] gin = 4'd0;
    logic       pos_clr = 1'b0;
    logic [7:0] pos;
    logic       step;
    logic       dir;
    logic       err;
    logic [3:0] err_cnt;
    logic       locked;

    int tests = 0;
    int fails = 0;

    logic [15:0] obs;
    logic [15:0] exp_v;

    assign obs = {locked, err_cnt, err, dir, step, pos};

    gray_step_tracker #(.POS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .gin_valid (gin_valid),
        .gin       (gin),
        .pos_clr   (pos_clr),
        .pos       (pos),
        .step      (step),
        .dir       (dir),
        .err       (err),
        .err_cnt   (err_cnt),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, wait for the consuming edge, then settle past it.
    task automatic drive(input logic v, input logic [3:0] g, input logic c, input logic r);
        gin_valid = v;
        gin       = g;
        pos_clr   = c;
        rst       = r;
        @(posedge clk);
        #1;
        $display("[TB] rst=%b v=%b gin=%b clr=%b -> pos=%0d step=%b dir=%b err=%b err_cnt=%0d locked=%b",
                 r, v, g, c, pos, step, dir, err, err_cnt, locked);
        rst       = 1'b0;
        gin_valid = 1'b0;
        pos_clr   = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b1, 4'b0110, 1'b1, 1'b1);
        exp_v = {1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_state got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_up_steps;
        logic [3:0] g_seq [4];
        logic [7:0] p_seq [4];
        g_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        p_seq = '{8'd0, 8'd1, 8'd2, 8'd3};
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, g_seq[i], 1'b0, 1'b0);
            exp_v = {1'b1, 4'd0, 1'b0, (i != 0), (i != 0), p_seq[i]};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL up_step[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
        drive(1'b0, 4'b1111, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd3};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL valid_low_hold got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd3};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL delta_zero got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_wrap_and_clr;
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 8'd255};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL down_wrap got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL up_wrap got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 1'b1, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL clr_with_step got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        drive(1'b1, 4'b0011, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL clr_alone got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'd1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL step_after_clr got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_illegal;
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 4'b0011, 1'b0, 1'b0);
        exp_v = {1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL illegal_jump got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reacquire got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_err_saturate;
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'b0000, 1'b0, 1'b0);
            drive(1'b1, 4'b0011, 1'b0, 1'b0);
            exp_v = {1'b0, (i < 15) ? 4'(i + 1) : 4'd15, 1'b1, 1'b0, 1'b0, 8'd0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL err_sat[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        exp_v = {1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL clr_keeps_errcnt got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_track;
        logic [3:0] g_seq [7];
        g_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, g_seq[i], 1'b0, 1'b0);
        end
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'd7};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL pos_seven got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0001, 1'b0, 1'b1);
        exp_v = {1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_mid got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL first_after_reset got=%h want=%h", obs, exp_v);
        end
        drive(1'b1, 4'b0011, 1'b0, 1'b0);
        exp_v = {1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'd1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL step_after_reacq got=%h want=%h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_up_steps();
        test_wrap_and_clr();
        test_illegal();
        test_err_saturate();
        test_reset_mid_track();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
